// File: rtl/fq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fq_pkg : shared types and constants for the instruction-fetch queue         |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
package fq_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fq_state_e;

   localparam int          INSTR_BYTES = 4;
   localparam int          WORD_SHIFT  = 2;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fq_fifo : W-wide x DEPTH synchronous FIFO with flush and occupancy count    |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module fq_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = pop && !w_empty;
   // A full FIFO may still accept a write when the head leaves in the same cycle.
   assign w_push  = push && (!w_full || w_pop);
   assign rdata   = r_mem[r_rd_ptr];
   assign count   = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push && !flush) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush) begin
         a_no_overflow : assert (!(push && w_full && !w_pop));
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue : fetch PC, credit-limited memory requests, instruction buffer  |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module fetch_queue
   import fq_pkg::*;
#(
   parameter int           N        = 32,
   parameter int           DEPTH    = 4,
   parameter logic [N-1:0] RESET_PC = N'(32'h0000_0000)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         redirect_i,
   input  logic [N-1:0] redirect_pc_i,
   input  logic         halt_i,
   output logic         mem_req_o,
   output logic [N-1:0] mem_addr_o,
   input  logic         mem_gnt_i,
   input  logic         mem_rvalid_i,
   input  logic [N-1:0] mem_rdata_i,
   output logic         inst_valid_o,
   output logic [N-1:0] inst_o,
   output logic [N-1:0] inst_pc_o,
   input  logic         inst_ready_i
);

   localparam int           CW      = $clog2(DEPTH + 1);
   // Squashed responses can still be outstanding while a full window of new
   // requests is issued, so the in-flight tally carries one extra bit.
   localparam int           IW      = CW + 1;
   localparam int           SW      = CW + 2;
   localparam logic [N-1:0] PC_MASK = ~N'(INSTR_BYTES - 1);

   fq_state_e     r_state;
   logic [N-1:0]  r_pc;
   logic [IW-1:0] r_inflight;
   logic [IW-1:0] r_drop_cnt;

   logic [CW-1:0] w_count;
   logic [CW-1:0] w_tag_count;
   logic [N-1:0]  w_tag;
   logic [SW-1:0] w_occupancy;
   logic          w_issue;
   logic          w_resp_live;
   logic          w_pop;

   assign w_occupancy = SW'(w_count) + SW'(r_inflight - r_drop_cnt);
   assign mem_req_o   = (r_state == ST_RUN) && !redirect_i && (w_occupancy < SW'(DEPTH));
   assign mem_addr_o  = r_pc >> WORD_SHIFT;
   assign w_issue     = mem_req_o && mem_gnt_i;
   assign w_resp_live = mem_rvalid_i && !redirect_i && (r_drop_cnt == '0);
   assign inst_valid_o = (w_count != '0);
   assign w_pop       = inst_valid_o && inst_ready_i && !redirect_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_BOOT;
      end else begin
         case (r_state)
            ST_BOOT: r_state <= ST_RUN;
            ST_RUN:  if (halt_i)  r_state <= ST_HALT;
            ST_HALT: if (!halt_i) r_state <= ST_RUN;
            default: r_state <= ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC & PC_MASK;
         r_inflight <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (redirect_i) r_pc <= redirect_pc_i & PC_MASK;
         else if (w_issue) r_pc <= r_pc + N'(INSTR_BYTES);

         r_inflight <= r_inflight + IW'(w_issue) - IW'(mem_rvalid_i);

         // Everything still outstanding at a redirect belongs to the old path.
         if (redirect_i) r_drop_cnt <= r_inflight - IW'(mem_rvalid_i);
         else if (mem_rvalid_i && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - IW'(1);
      end
   end

   // Tags of squashed requests are flushed at redirect, so only live requests
   // ever occupy the tag queue and it pops only on live responses.
   fq_fifo #(
      .W     (N),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_i),
      .push  (w_issue),
      .wdata (r_pc),
      .pop   (w_resp_live),
      .rdata (w_tag),
      .count (w_tag_count)
   );

   fq_fifo #(
      .W     (2 * N),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_inst_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_i),
      .push  (w_resp_live),
      .wdata ({mem_rdata_i, w_tag}),
      .pop   (w_pop),
      .rdata ({inst_o, inst_pc_o}),
      .count (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_tag_present : assert (!(w_resp_live && (w_tag_count == '0)));
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_queue : randomized bench with a queue-based reference of fetch_queue|
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

   localparam int N      = 32;
   localparam int DEPTH  = 4;
   localparam int M_BOOT = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         redirect_i;
   logic [N-1:0] redirect_pc_i;
   logic         halt_i;
   logic         mem_req_o;
   logic [N-1:0] mem_addr_o;
   logic         mem_gnt_i;
   logic         mem_rvalid_i;
   logic [N-1:0] mem_rdata_i;
   logic         inst_valid_o;
   logic [N-1:0] inst_o;
   logic [N-1:0] inst_pc_o;
   logic         inst_ready_i;

   always #5 clk = ~clk;

   fetch_queue #(
      .N        (N),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .halt_i        (halt_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_ready_i  (inst_ready_i)
   );

   typedef struct { logic [31:0] pc;   bit sq; }  os_t;   // outstanding request
   typedef struct { logic [31:0] inst; logic [31:0] pc; } fe_t; // buffered word
   typedef struct { logic [31:0] addr; int due; } mr_t;   // memory pipeline slot

   os_t os_q[$];
   fe_t fe_q[$];
   mr_t mq[$];
   int          st;
   logic [31:0] mpc;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   bit  d_gnt, d_ready, d_halt, d_redirect;
   logic [31:0] d_rpc;
   int  lat_min = 1, lat_max = 1;
   bit  last_req, last_valid;
   logic [31:0] g_log[$];
   logic [31:0] d_log[$];

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic set_knobs(input bit g, input bit r, input int lmin, input int lmax);
      d_gnt = g; d_ready = r; d_halt = 0; d_redirect = 0; d_rpc = 32'h0;
      lat_min = lmin; lat_max = lmax;
      g_log.delete(); d_log.delete();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      redirect_i = 0; redirect_pc_i = '0; halt_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; inst_ready_i = 0;
      st = M_BOOT; mpc = 32'h0;
      os_q.delete(); fe_q.delete(); mq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive at the falling edge, check, advance the reference model.
   task automatic step();
      bit   rv, exp_req, have_o;
      int   live, due;
      os_t  o;
      cyc++;
      rv = (mq.size() != 0) && (mq[0].due <= cyc);
      mem_rvalid_i  = rv;
      mem_rdata_i   = rv ? hash(mq[0].addr) : 32'h0;
      mem_gnt_i     = d_gnt;
      inst_ready_i  = d_ready;
      halt_i        = d_halt;
      redirect_i    = d_redirect;
      redirect_pc_i = d_rpc;
      #1;
      live = 0;
      foreach (os_q[i]) if (!os_q[i].sq) live++;
      exp_req = (st == M_RUN) && !d_redirect && ((fe_q.size() + live) < DEPTH);

      n_cmp++;
      if (mem_req_o !== exp_req) begin
         n_bad++;
         $display("FAIL mem_req cyc=%0d got=%b expected=%b", cyc, mem_req_o, exp_req);
      end
      if (exp_req) begin
         n_cmp++;
         if (mem_addr_o !== {2'b00, mpc[31:2]}) begin
            n_bad++;
            $display("FAIL mem_addr cyc=%0d got=%h expected=%h", cyc, mem_addr_o, {2'b00, mpc[31:2]});
         end
      end
      n_cmp++;
      if (inst_valid_o !== (fe_q.size() != 0)) begin
         n_bad++;
         $display("FAIL inst_valid cyc=%0d got=%b expected=%b", cyc, inst_valid_o, fe_q.size() != 0);
      end
      if (fe_q.size() != 0) begin
         n_cmp++;
         if (inst_o !== fe_q[0].inst || inst_pc_o !== fe_q[0].pc) begin
            n_bad++;
            $display("FAIL inst_head cyc=%0d got=%h/%h expected=%h/%h",
                     cyc, inst_o, inst_pc_o, fe_q[0].inst, fe_q[0].pc);
         end
      end

      last_req   = mem_req_o;
      last_valid = inst_valid_o;
      if (mem_req_o && d_gnt) begin
         due = cyc + $urandom_range(lat_max, lat_min);
         if (mq.size() != 0 && mq[$].due >= due) due = mq[$].due + 1;
         mq.push_back('{mem_addr_o, due});
         g_log.push_back(mem_addr_o);
      end
      if (rv) void'(mq.pop_front());
      if (inst_valid_o && d_ready && !d_redirect) d_log.push_back(inst_pc_o);

      have_o = 0;
      if (rv) begin
         n_cmp++;
         if (os_q.size() == 0) begin
            n_bad++;
            $display("FAIL resp_without_request cyc=%0d got=1 outstanding expected=0", cyc);
         end else begin
            o = os_q.pop_front();
            have_o = 1;
         end
      end
      if ((fe_q.size() != 0) && d_ready && !d_redirect) void'(fe_q.pop_front());
      if (have_o && !o.sq && !d_redirect) fe_q.push_back('{hash({2'b00, o.pc[31:2]}), o.pc});
      if (d_redirect) begin
         fe_q.delete();
         foreach (os_q[i]) os_q[i].sq = 1;
         mpc = d_rpc & ~32'h3;
      end else if (exp_req && d_gnt) begin
         os_q.push_back('{mpc, 1'b0});
         mpc = mpc + 32'd4;
      end
      case (st)
         M_BOOT:  st = M_RUN;
         M_RUN:   if (d_halt)  st = M_HALT;
         default: if (!d_halt) st = M_RUN;
      endcase
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      redirect_i = 0; redirect_pc_i = '0; halt_i = 0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; inst_ready_i = 0;
      #1;
      n_cmp++;
      if ({mem_req_o, inst_valid_o} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_ctrl got=%b expected=00", {mem_req_o, inst_valid_o});
      end
      n_cmp++;
      if ({mem_addr_o, inst_o, inst_pc_o} !== 96'h0) begin
         n_bad++;
         $display("FAIL reset_data got=%h/%h/%h expected=0", mem_addr_o, inst_o, inst_pc_o);
      end
      apply_reset();
   endtask

   task automatic test_first_fetch();
      int first;
      apply_reset();
      set_knobs(1, 1, 1, 1);
      first = -1;
      for (int i = 1; i <= 9; i++) begin
         step();
         if (last_req && first < 0) first = i;
         if (i == 5) begin
            n_cmp++;
            if (g_log.size() != 4) begin
               n_bad++;
               $display("FAIL b2b_grants got=%0d expected=4", g_log.size());
            end
         end
      end
      n_cmp++;
      if (first != 2) begin
         n_bad++;
         $display("FAIL first_req_cycle got=%0d expected=2", first);
      end
      n_cmp++;
      if (g_log.size() < 4 || d_log.size() < 4) begin
         n_bad++;
         $display("FAIL first_fetch_len got=%0d/%0d expected=4/4", g_log.size(), d_log.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (g_log[k] !== 32'(k) || d_log[k] !== 32'(4 * k)) begin
               n_bad++;
               $display("FAIL first_fetch_seq k=%0d got=%h/%h expected=%h/%h",
                        k, g_log[k], d_log[k], 32'(k), 32'(4 * k));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      apply_reset();
      set_knobs(1, 0, 3, 3);
      repeat (16) step();
      n_cmp++;
      if (g_log.size() != DEPTH) begin
         n_bad++;
         $display("FAIL bp_grants got=%0d expected=%0d", g_log.size(), DEPTH);
      end
      n_cmp++;
      if (last_req !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_req_stall got=%b expected=0", last_req);
      end
      n = g_log.size();
      d_ready = 1;
      repeat (12) step();
      n_cmp++;
      if (g_log.size() <= n || d_log.size() < 4 || d_log[0] !== 32'h0) begin
         n_bad++;
         $display("FAIL bp_resume got grants=%0d delivered=%0d expected more than %0d grants", g_log.size(), d_log.size(), n);
      end
   endtask

   task automatic test_redirect();
      int budget;
      apply_reset();
      set_knobs(1, 1, 4, 4);
      repeat (3) step();
      d_redirect = 1; d_rpc = 32'h0000_0102;
      step();
      d_redirect = 0;
      g_log.delete(); d_log.delete();
      step();
      n_cmp++;
      if (g_log.size() != 1 || g_log[0] !== 32'h40) begin
         n_bad++;
         $display("FAIL redirect_addr got=%0d grants first=%h expected=1 grant at 00000040",
                  g_log.size(), (g_log.size() != 0) ? g_log[0] : 32'hx);
      end
      budget = 0;
      while (d_log.size() == 0 && budget < 20) begin step(); budget++; end
      n_cmp++;
      if (d_log.size() == 0 || d_log[0] !== 32'h0000_0100) begin
         n_bad++;
         $display("FAIL redirect_head got=%h expected=00000100", (d_log.size() != 0) ? d_log[0] : 32'hx);
      end
   endtask

   task automatic test_redirect_collide();
      int budget;
      apply_reset();
      set_knobs(1, 1, 1, 1);
      repeat (6) step();
      d_redirect = 1; d_rpc = 32'h0000_0200;
      step();
      d_redirect = 0;
      d_log.delete();
      step();
      n_cmp++;
      if (last_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL collide_flush got=%b expected=0", last_valid);
      end
      budget = 0;
      while (d_log.size() == 0 && budget < 20) begin step(); budget++; end
      n_cmp++;
      if (d_log.size() == 0 || d_log[0] !== 32'h0000_0200) begin
         n_bad++;
         $display("FAIL collide_head got=%h expected=00000200", (d_log.size() != 0) ? d_log[0] : 32'hx);
      end
   endtask

   task automatic test_halt();
      apply_reset();
      set_knobs(1, 1, 3, 3);
      repeat (3) step();
      d_halt = 1; d_gnt = 0;
      step();
      d_gnt = 1;
      g_log.delete(); d_log.delete();
      repeat (6) step();
      n_cmp++;
      if (g_log.size() != 0 || d_log.size() != 2) begin
         n_bad++;
         $display("FAIL halt_drain got grants=%0d words=%0d expected=0/2", g_log.size(), d_log.size());
      end
      d_halt = 0;
      g_log.delete();
      repeat (3) step();
      n_cmp++;
      if (g_log.size() == 0 || g_log[0] !== 32'h2) begin
         n_bad++;
         $display("FAIL halt_resume got=%h expected=00000002", (g_log.size() != 0) ? g_log[0] : 32'hx);
      end
   endtask

   task automatic test_wrap_and_async_reset();
      apply_reset();
      set_knobs(1, 1, 1, 1);
      step();
      d_redirect = 1; d_rpc = 32'hFFFF_FFFE;
      step();
      d_redirect = 0;
      g_log.delete();
      repeat (4) step();
      n_cmp++;
      if (g_log.size() < 2 || g_log[0] !== 32'h3FFF_FFFF || g_log[1] !== 32'h0) begin
         n_bad++;
         $display("FAIL pc_wrap got=%0d grants expected 3fffffff then 00000000", g_log.size());
      end
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_req_o, inst_valid_o} !== 2'b00 || {mem_addr_o, inst_o, inst_pc_o} !== 96'h0) begin
         n_bad++;
         $display("FAIL async_reset got=%b%b %h/%h/%h expected=all zero",
                  mem_req_o, inst_valid_o, mem_addr_o, inst_o, inst_pc_o);
      end
      apply_reset();
      set_knobs(1, 1, 1, 1);
      repeat (4) step();
      n_cmp++;
      if (g_log.size() == 0 || g_log[0] !== 32'h0) begin
         n_bad++;
         $display("FAIL restart_pc got=%h expected=00000000", (g_log.size() != 0) ? g_log[0] : 32'hx);
      end
   endtask

   task automatic test_random();
      apply_reset();
      set_knobs(1, 1, 1, 4);
      for (int i = 0; i < 600; i++) begin
         d_gnt      = ($urandom_range(9, 0) < 7);
         d_ready    = ($urandom_range(9, 0) < 6);
         if ($urandom_range(9, 0) == 0) d_halt = !d_halt;
         d_redirect = ($urandom_range(15, 0) == 0);
         d_rpc      = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
         step();
      end
      d_halt = 0; d_redirect = 0; d_gnt = 1; d_ready = 1;
      repeat (20) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      d_gnt = 0; d_ready = 0; d_halt = 0; d_redirect = 0; d_rpc = '0;
      test_reset();
      test_first_fetch();
      test_backpressure();
      test_redirect();
      test_redirect_collide();
      test_halt();
      test_wrap_and_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
